// File: rtl/qcl_button_pkg.sv
// qcl_button_pkg: shared event codes, FSM states and widths for the button event classifier
package qcl_button_pkg;
    localparam int qcl_button_event_width_gp = 2;
    typedef enum logic [1:0] {
        PRESS         = 2'b00,
        SHORT_RELEASE = 2'b01,
        LONG          = 2'b10,
        LONG_RELEASE  = 2'b11
    } qcl_button_event_e;
    typedef enum logic [1:0] {
        IDLE,
        HELD,
        HELD_LONG
    } qcl_button_state_e;
endpackage

// File: rtl/qcl_fifo_2.sv
// qcl_fifo_2: two-entry valid/yumi buffer with registered head
// Ports: clk_i, reset_n_i (async active-low); v_i/data_i enqueue side, full_o when both slots hold data;
//        v_o/data_o head of buffer, yumi_i consumer takes the head this cycle.
// Empty slots are kept at zero so data_o reads 0 whenever v_o is low.
module qcl_fifo_2 #(
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    logic [width_p-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
    logic v0_q, v0_d, v1_q, v1_d;
    logic deq, enq, rem0, rem1;
    always_comb begin
        deq    = yumi_i & v0_q;
        enq    = v_i & (~v1_q | deq);
        // occupancy once the dequeue has shifted slot 1 into slot 0
        rem0   = deq ? v1_q : v0_q;
        rem1   = deq ? 1'b0 : v1_q;
        mem0_d = (enq && !rem0) ? data_i : deq ? mem1_q : mem0_q;
        mem1_d = (enq && rem0) ? data_i : deq ? '0 : mem1_q;
        v0_d   = rem0 | enq;
        v1_d   = rem1 | (enq & rem0);
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem0_q <= '0;
            mem1_q <= '0;
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            v0_q   <= v0_d;
            v1_q   <= v1_d;
        end
    end
    assign full_o = v1_q;
    assign v_o    = v0_q;
    assign data_o = mem0_q;
endmodule

// File: rtl/qcl_button_event.sv
// qcl_button_event: classifies a debounced button level into press/release/long events on a valid/yumi stream
// Ports: clk_i, reset_n_i (async active-low); i debounced level (1 = pressed);
//        v_o/event_o head event, yumi_i consumer takes it; overflow_o sticky dropped-event flag.
// Build option: QCL_BUTTON_EVENT_LONG_EN enables the hold counter, LONG and LONG_RELEASE.
module qcl_button_event
    import qcl_button_pkg::*;
#(
    parameter int long_cycles_p = 50_000_000,
    parameter int cnt_width_p   = $clog2(long_cycles_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 i,
    output logic                                 v_o,
    output logic [qcl_button_event_width_gp-1:0] event_o,
    input  logic                                 yumi_i,
    output logic                                 overflow_o
);
    qcl_button_state_e state_q, state_d;
    qcl_button_event_e enq_event;
    logic i_r_q, overflow_q, overflow_d;
    logic rise, fall, enq_v, full, long_hit;
`ifdef QCL_BUTTON_EVENT_LONG_EN
    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    assign long_hit = (state_q == HELD) && i && (cnt_q == cnt_width_p'(long_cycles_p - 1));
    // counter runs only while HELD; held at zero in IDLE and frozen in HELD_LONG
    assign cnt_d = (state_q == IDLE) ? '0
                 : (state_q == HELD && !fall && !long_hit && cnt_q != '1) ? cnt_q + cnt_width_p'(1)
                 : cnt_q;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    logic unused_cfg;
    assign long_hit   = 1'b0;
    assign unused_cfg = ^{long_cycles_p, cnt_width_p};
`endif
    always_comb begin
        rise      = i & ~i_r_q;
        fall      = ~i & i_r_q;
        state_d   = state_q;
        enq_v     = 1'b0;
        enq_event = PRESS;
        unique case (state_q)
            IDLE: if (rise) begin
                enq_v   = 1'b1;
                state_d = HELD;
            end
            // a release on the same edge as the long threshold counts as short
            HELD: if (fall) begin
                enq_v     = 1'b1;
                enq_event = SHORT_RELEASE;
                state_d   = IDLE;
            end else if (long_hit) begin
                enq_v     = 1'b1;
                enq_event = LONG;
                state_d   = HELD_LONG;
            end
            HELD_LONG: if (fall) begin
                enq_v     = 1'b1;
                enq_event = LONG_RELEASE;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        overflow_d = overflow_q | (enq_v & full & ~(yumi_i & v_o));
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            i_r_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_r_q      <= i;
            overflow_q <= overflow_d;
        end
    end
    qcl_fifo_2 #(.width_p(qcl_button_event_width_gp)) fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (enq_v),
        .data_i   (enq_event),
        .full_o   (full),
        .v_o      (v_o),
        .data_o   (event_o),
        .yumi_i   (yumi_i)
    );
    assign overflow_o = overflow_q;
endmodule

// File: tb/tb_qcl_button_event.sv
// tb_qcl_button_event: directed bench for qcl_button_event with long_cycles_p = 8
module tb_qcl_button_event;
    import qcl_button_pkg::*;
    logic clk = 1'b0, reset_n = 1'b0, btn = 1'b0, yumi = 1'b0;
    logic v, ovf;
    logic [1:0] ev;
    int tests = 0, fails = 0, cyc = 0;
    logic [1:0] log_ev[$];
    int log_cy[$];

    qcl_button_event #(.long_cycles_p(8)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .i         (btn),
        .v_o       (v),
        .event_o   (ev),
        .yumi_i    (yumi),
        .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    // record every accepted handshake with the edge index it completed on
    always @(posedge clk) begin
        if (v && yumi) begin
            log_ev.push_back(ev);
            log_cy.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input int n);
        btn = 1'b1;
        step(n);
        btn = 1'b0;
    endtask

    task automatic clear_log;
        log_ev.delete();
        log_cy.delete();
    endtask

    task automatic test_reset;
        reset_n = 1'b0; btn = 1'b0; yumi = 1'b0;
        step(2);
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL reset_v: got %b want 0", v); end
        tests++; if (ev !== 2'b00) begin fails++; $display("FAIL reset_event: got %b want 00", ev); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        reset_n = 1'b1;
        step(2);
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL reset_idle_v: got %b want 0", v); end
    endtask

    task automatic test_short_press;
        yumi = 1'b1;
        clear_log();
        btn = 1'b1;
        step(1);
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL short_v_rise: got %b want 1", v); end
        tests++; if (ev !== PRESS) begin fails++; $display("FAIL short_head: got %b want %b", ev, PRESS); end
        step(2);
        btn = 1'b0;
        step(5);
        tests++; if (log_ev.size() != 2) begin fails++; $display("FAIL short_count: got %0d want 2", log_ev.size()); end
        tests++; if (log_ev[0] !== PRESS) begin fails++; $display("FAIL short_ev0: got %b want %b", log_ev[0], PRESS); end
        tests++; if (log_ev[1] !== SHORT_RELEASE) begin fails++; $display("FAIL short_ev1: got %b want %b", log_ev[1], SHORT_RELEASE); end
        tests++; if (log_cy[1] - log_cy[0] != 3) begin fails++; $display("FAIL short_gap: got %0d want 3", log_cy[1] - log_cy[0]); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL short_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_long_hold;
        logic [1:0] exp_ev[$];
        int exp_gap[$];
`ifdef QCL_BUTTON_EVENT_LONG_EN
        exp_ev = '{PRESS, LONG, LONG_RELEASE};
        exp_gap = '{8, 12};
`else
        exp_ev = '{PRESS, SHORT_RELEASE};
        exp_gap = '{20};
`endif
        yumi = 1'b1;
        clear_log();
        hold(20);
        step(5);
        tests++; if (log_ev.size() != exp_ev.size()) begin fails++; $display("FAIL long_count: got %0d want %0d", log_ev.size(), exp_ev.size()); end
        for (int k = 0; k < exp_ev.size(); k++) begin
            tests++; if (log_ev[k] !== exp_ev[k]) begin fails++; $display("FAIL long_ev%0d: got %b want %b", k, log_ev[k], exp_ev[k]); end
        end
        for (int k = 0; k < exp_gap.size(); k++) begin
            tests++; if (log_cy[k+1] - log_cy[k] != exp_gap[k]) begin fails++; $display("FAIL long_gap%0d: got %0d want %0d", k, log_cy[k+1] - log_cy[k], exp_gap[k]); end
        end
    endtask

    task automatic test_boundary;
        yumi = 1'b1;
        clear_log();
        hold(8);
        step(5);
        tests++; if (log_ev.size() != 2) begin fails++; $display("FAIL bound_count: got %0d want 2", log_ev.size()); end
        tests++; if (log_ev[0] !== PRESS) begin fails++; $display("FAIL bound_ev0: got %b want %b", log_ev[0], PRESS); end
        tests++; if (log_ev[1] !== SHORT_RELEASE) begin fails++; $display("FAIL bound_ev1: got %b want %b", log_ev[1], SHORT_RELEASE); end
        tests++; if (log_cy[1] - log_cy[0] != 8) begin fails++; $display("FAIL bound_gap: got %0d want 8", log_cy[1] - log_cy[0]); end
    endtask

    task automatic test_overflow;
        logic [1:0] second;
`ifdef QCL_BUTTON_EVENT_LONG_EN
        second = LONG;
`else
        second = SHORT_RELEASE;
`endif
        yumi = 1'b0;
        hold(20);
        step(2);
        hold(3);
        step(3);
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", ovf); end
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL ovf_v: got %b want 1", v); end
        tests++; if (ev !== PRESS) begin fails++; $display("FAIL ovf_head0: got %b want %b", ev, PRESS); end
        yumi = 1'b1;
        step(1);
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL ovf_v1: got %b want 1", v); end
        tests++; if (ev !== second) begin fails++; $display("FAIL ovf_head1: got %b want %b", ev, second); end
        step(1);
        yumi = 1'b0;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL ovf_drained_v: got %b want 0", v); end
        tests++; if (ev !== 2'b00) begin fails++; $display("FAIL ovf_drained_ev: got %b want 00", ev); end
        tests++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    endtask

    task automatic test_reset_mid_hold;
        yumi = 1'b0;
        btn = 1'b1;
        step(6);
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL rmid_pending: got %b want 1", v); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL rmid_async_v: got %b want 0", v); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL rmid_async_ovf: got %b want 0", ovf); end
        tests++; if (ev !== 2'b00) begin fails++; $display("FAIL rmid_async_ev: got %b want 00", ev); end
        step(1);
        reset_n = 1'b1;
        clear_log();
        step(1);
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL rmid_press_v: got %b want 1", v); end
        tests++; if (ev !== PRESS) begin fails++; $display("FAIL rmid_press_ev: got %b want %b", ev, PRESS); end
        yumi = 1'b1;
        btn = 1'b0;
        step(4);
        yumi = 1'b0;
        tests++; if (log_ev.size() != 2) begin fails++; $display("FAIL rmid_count: got %0d want 2", log_ev.size()); end
        tests++; if (log_ev[1] !== SHORT_RELEASE) begin fails++; $display("FAIL rmid_release: got %b want %b", log_ev[1], SHORT_RELEASE); end
    endtask

    task automatic test_full_yumi;
        logic [1:0] exp_ev[$];
        int exp_gap[$];
        clear_log();
        yumi = 1'b0;
`ifdef QCL_BUTTON_EVENT_LONG_EN
        exp_ev = '{PRESS, LONG, LONG_RELEASE};
        exp_gap = '{1, 1};
        btn = 1'b1;
        step(20);
        btn = 1'b0;
        yumi = 1'b1;
        step(5);
`else
        exp_ev = '{PRESS, SHORT_RELEASE, PRESS, SHORT_RELEASE};
        exp_gap = '{1, 1, 2};
        hold(3);
        step(2);
        btn = 1'b1;
        yumi = 1'b1;
        step(3);
        btn = 1'b0;
        step(4);
`endif
        yumi = 1'b0;
        tests++; if (log_ev.size() != exp_ev.size()) begin fails++; $display("FAIL fully_count: got %0d want %0d", log_ev.size(), exp_ev.size()); end
        for (int k = 0; k < exp_ev.size(); k++) begin
            tests++; if (log_ev[k] !== exp_ev[k]) begin fails++; $display("FAIL fully_ev%0d: got %b want %b", k, log_ev[k], exp_ev[k]); end
        end
        for (int k = 0; k < exp_gap.size(); k++) begin
            tests++; if (log_cy[k+1] - log_cy[k] != exp_gap[k]) begin fails++; $display("FAIL fully_gap%0d: got %0d want %0d", k, log_cy[k+1] - log_cy[k], exp_gap[k]); end
        end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL fully_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_ev[$];
        exp_ev = '{PRESS, SHORT_RELEASE, PRESS, SHORT_RELEASE};
        clear_log();
        yumi = 1'b1;
        hold(1);
        step(1);
        hold(1);
        step(5);
        yumi = 1'b0;
        tests++; if (log_ev.size() != 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", log_ev.size()); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (log_ev[k] !== exp_ev[k]) begin fails++; $display("FAIL b2b_ev%0d: got %b want %b", k, log_ev[k], exp_ev[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            tests++; if (log_cy[k+1] - log_cy[k] != 1) begin fails++; $display("FAIL b2b_gap%0d: got %0d want 1", k, log_cy[k+1] - log_cy[k]); end
        end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_boundary();
        test_overflow();
        test_reset_mid_hold();
        test_full_yumi();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
